// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage state encoding and pipeline constants
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_IR     = 32'b0;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register for IR/PC+4/valid with flush-over-hold priority
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] d_ir,
    input  logic [31:0] d_pc4,
    output logic [31:0] ir,
    output logic [31:0] pc4,
    output logic        valid
);

    // flush inserts a bubble even while held; otherwise load when not held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= NOP_IR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            ir    <= NOP_IR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load && !hold) begin
            ir    <= d_ir;
            pc4   <= d_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage owning the PC, one-outstanding imem requests and IF/ID
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [31:0]       if_id_ir,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       hold_ir;
    logic [ADDR_W-1:0] pc_plus4;
    logic              rsp_take;
    logic              deliver;

    assign pc_plus4 = pc + ADDR_W'(WORD_BYTES);
    assign rsp_take = (state == WAIT) && imem_rvalid;
    assign deliver  = !stall && (rsp_take || (state == FULL));

    // request in FETCH, or chained to the response that is being delivered this cycle;
    // reset gating keeps the port quiet while rst_n is low
    always_comb begin
        imem_req  = rst_n && ((state == FETCH) || (rsp_take && !stall && !redirect));
        imem_addr = imem_req ? ((state == FETCH) ? pc : pc_plus4) : '0;
    end

    // FSM, PC and the single-entry skid buffer; redirect overrides stall and rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC & ALIGN_MASK;
            hold_ir <= NOP_IR;
        end else if (redirect) begin
            pc      <= redirect_target & ALIGN_MASK;
            hold_ir <= NOP_IR;
            state   <= ((state == FULL) || imem_rvalid && (state != FETCH)) ? FETCH : DROP;
        end else begin
            case (state)
                FETCH: state <= WAIT;
                WAIT: if (imem_rvalid) begin
                    if (stall) begin
                        hold_ir <= imem_rdata;
                        state   <= FULL;
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                FULL: if (!stall) begin
                    pc      <= pc_plus4;
                    hold_ir <= NOP_IR;
                    state   <= FETCH;
                end
                DROP: if (imem_rvalid) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (deliver),
        .hold  (stall),
        .flush (redirect || (!stall && !deliver)),
        .d_ir  ((state == FULL) ? hold_ir : imem_rdata),
        .d_pc4 (pc_plus4),
        .ir    (if_id_ir),
        .pc4   (if_id_pc4),
        .valid (if_id_valid)
    );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the textbook MIPS pipeline.
- Producer side of the IR consumed by the instruction decoder/control unit.
- Owns the PC and issues one-outstanding requests to instruction memory.
- Drives the IF/ID register (IR, PC+4) and handles stall (hold), redirect (branch/jump flush) and bubble insertion. A bubble is IR = 32'b0, which the decoder treats as all-controls-zero.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; fixed at 32 for the MIPS datapath.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_rvalid  in  1  response strobe: exactly one per request, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect  in  1  taken branch or jump: flush and reload PC.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 0.
- if_id_ir  out  32  IR to decode; 0 = bubble.
- if_id_pc4  out  32  PC+4 of the instruction in if_id_ir.
- if_id_valid  out  1  1 when if_id_ir holds a real fetched instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - if_id_ir=0, if_id_pc4=0, if_id_valid=0.
  - imem_req=0; buffer empty.
- States: FETCH, WAIT, FULL, DROP.
- FETCH: imem_req=1, imem_addr=pc; next state WAIT. Not gated by stall.
- WAIT, imem_rvalid=0: hold.
- WAIT, imem_rvalid=1, stall=0:
  - IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4.
  - The next request issues in the same cycle (imem_req=1, imem_addr=pc+4); stay in WAIT. This gives back-to-back fetch at 1-cycle memory latency.
- WAIT, imem_rvalid=1, stall=1: capture rdata into the 1-entry buffer; IF/ID holds; go to FULL; no request.
- FULL, stall=1: hold everything.
- FULL, stall=0: IF/ID <= buffer (valid=1); pc <= pc+4; buffer empties; go to FETCH.
- Bubble: stall=0 and no instruction delivered this cycle -> IF/ID <= {0, 0, valid=0}.
- stall=1 with no redirect: IF/ID and pc are unchanged.
- Redirect (priority over stall and over rvalid):
  - pc <= {redirect_target[31:2], 2'b00}; IF/ID <= bubble; buffer cleared.
  - State mapping:
    - FETCH -> DROP (its request is in flight).
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid -> rdata discarded, -> FETCH.
    - FULL -> FETCH.
    - DROP without rvalid -> stay DROP, pc updated.
    - DROP with rvalid -> FETCH.
- DROP without redirect: wait for rvalid, discard the data, go to FETCH. IF/ID shows bubbles unless stall holds it.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Mid-operation reset: an outstanding imem response arriving after reset release and before any new request is ignored. Requirement on imem: it must also be reset, or the bench guarantees none arrive.
- Invariants:
  - At most one outstanding request.
  - imem_req is never asserted in FULL or DROP.
  - if_id_valid=0 implies if_id_ir=0.

Decomposition:
- Shared package mips_pkg:
  - state encoding localparams (FETCH/WAIT/FULL/DROP);
  - NOP_IR = 32'b0;
  - WORD_BYTES = 4.
- Sub-module: if_id_reg. Holds if_id_ir, if_id_pc4 and if_id_valid, with load, hold and flush inputs, and flush-over-hold priority. It is reused by the later ID/EX register pattern.
- The FSM, PC and buffer stay in the top module.

Test Plan:
- Reset release, memory latency 1, program at 0x0 = {0x20080005, 0x8D090004, 0xAD090008}:
  - IR sequence matches the program with pc4 = 0x4, 0x8, 0xC;
  - imem_addr = 0x0, 0x4, 0x8, 0xC on consecutive requests after the first.
- stall high for 3 cycles while rvalid returns 0x01095020:
  - IF/ID holds its old value; state FULL; no imem_req;
  - on stall release, IR=0x01095020 next cycle and a request to pc+4 follows.
- redirect to 0x00000043 while WAIT with no rvalid:
  - IF/ID becomes 0/valid 0;
  - the late response (0xDEADBEEF) is dropped;
  - the next request has addr 0x40.
- redirect and stall high in the same cycle with rvalid=1:
  - redirect wins; data discarded; IR=0; next request to the target.
- PC wrap:
  - RESET_PC=0xFFFFFFFC, instruction 0x08000000 -> if_id_pc4 = 0x0 and the next imem_addr = 0x0.
- Async reset asserted mid-WAIT with the buffer full:
  - all outputs are 0 immediately, without waiting for a clock edge;
  - after release, the first request goes to RESET_PC.
